// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter for two result sources (ALU, LSB).
// Each source feeds its own DEPTH-entry FIFO of {robIndex, value}; at most one
// entry per cycle is popped and broadcast on the registered CDB outputs.
// Ports:
//   clockIn, resetIn            clock, async active-low reset
//   readyIn                     global enable; low freezes every register
//   flushIn                     empties both queues, suppresses the broadcast
//   alu*/lsb* Valid/RobIndex/Val  source results; *Full is the near-full backpressure
//   cdbValid/RobIndex/Val/FromLsb  registered broadcast
//   overflow                    sticky flag: a push was dropped on a full queue
module cdb_arbiter #(
    parameter int unsigned ROB_WIDTH   = 4,
    parameter int unsigned QUEUE_WIDTH = 2
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 flushIn,
    input  logic                 aluValid,
    input  logic [ROB_WIDTH-1:0] aluRobIndex,
    input  logic [31:0]          aluVal,
    output logic                 aluFull,
    input  logic                 lsbValid,
    input  logic [ROB_WIDTH-1:0] lsbRobIndex,
    input  logic [31:0]          lsbVal,
    output logic                 lsbFull,
    output logic                 cdbValid,
    output logic [ROB_WIDTH-1:0] cdbRobIndex,
    output logic [31:0]          cdbVal,
    output logic                 cdbFromLsb,
    output logic                 overflow
);

    localparam int unsigned DEPTH       = 1 << QUEUE_WIDTH;
    localparam int unsigned COUNT_WIDTH = QUEUE_WIDTH + 1;
    localparam int unsigned VAL_WIDTH   = 32;
    localparam int unsigned NUM_SRC     = 2;

    // Source index 0 = ALU, 1 = LSB throughout.
    logic [ROB_WIDTH-1:0]   robMem   [NUM_SRC][DEPTH];
    logic [VAL_WIDTH-1:0]   valMem   [NUM_SRC][DEPTH];
    logic [QUEUE_WIDTH-1:0] headPtr  [NUM_SRC];
    logic [QUEUE_WIDTH-1:0] tailPtr  [NUM_SRC];
    logic [COUNT_WIDTH-1:0] count    [NUM_SRC];
    logic                   lastGrantLsb;

    logic [NUM_SRC-1:0]     srcValid;
    logic [ROB_WIDTH-1:0]   srcRob   [NUM_SRC];
    logic [VAL_WIDTH-1:0]   srcVal   [NUM_SRC];

    logic [NUM_SRC-1:0]     nonEmpty;
    logic [NUM_SRC-1:0]     doPush;
    logic [NUM_SRC-1:0]     doPop;
    logic [NUM_SRC-1:0]     doDrop;
    logic                   grantLsb;

    assign srcValid  = {lsbValid, aluValid};
    assign srcRob[0] = aluRobIndex;
    assign srcRob[1] = lsbRobIndex;
    assign srcVal[0] = aluVal;
    assign srcVal[1] = lsbVal;

    // Near-full leaves one slot for the cycle the source needs to react.
    assign aluFull = (count[0] >= COUNT_WIDTH'(DEPTH - 1));
    assign lsbFull = (count[1] >= COUNT_WIDTH'(DEPTH - 1));

    // Grant and push/pop decisions from the counts held before this edge.
    always_comb begin
        nonEmpty = '0;
        doPush   = '0;
        doPop    = '0;
        doDrop   = '0;
        grantLsb = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            nonEmpty[i] = (count[i] != '0);
        end
        // On a tie the queue not served last time wins.
        grantLsb = (nonEmpty == 2'b11) ? !lastGrantLsb : nonEmpty[1];
        if (readyIn && !flushIn) begin
            doPop[1] = nonEmpty[1] && grantLsb;
            doPop[0] = nonEmpty[0] && !grantLsb;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (srcValid[i]) begin
                    // A same-edge pop frees the slot even when the queue is full.
                    if ((count[i] != COUNT_WIDTH'(DEPTH)) || doPop[i]) begin
                        doPush[i] = 1'b1;
                    end else begin
                        doDrop[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Queue storage; contents are don't-care outside the head..tail window.
    always_ff @(posedge clockIn) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (doPush[i]) begin
                robMem[i][tailPtr[i]] <= srcRob[i];
                valMem[i][tailPtr[i]] <= srcVal[i];
            end
        end
    end

    // Queue pointers/counts, arbitration history and the CDB broadcast registers.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            headPtr      <= '{default: '0};
            tailPtr      <= '{default: '0};
            count        <= '{default: '0};
            lastGrantLsb <= 1'b1;
            cdbValid     <= 1'b0;
            cdbRobIndex  <= '0;
            cdbVal       <= '0;
            cdbFromLsb   <= 1'b0;
            overflow     <= 1'b0;
        end else if (readyIn) begin
            if (flushIn) begin
                headPtr  <= '{default: '0};
                tailPtr  <= '{default: '0};
                count    <= '{default: '0};
                cdbValid <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (doPush[i]) begin
                        tailPtr[i] <= QUEUE_WIDTH'(tailPtr[i] + 1'b1);
                    end
                    if (doPop[i]) begin
                        headPtr[i] <= QUEUE_WIDTH'(headPtr[i] + 1'b1);
                    end
                    count[i] <= COUNT_WIDTH'(count[i] + COUNT_WIDTH'(doPush[i])
                                             - COUNT_WIDTH'(doPop[i]));
                end
                cdbValid <= |doPop;
                if (|doPop) begin
                    cdbRobIndex  <= robMem[doPop[1]][headPtr[doPop[1]]];
                    cdbVal       <= valMem[doPop[1]][headPtr[doPop[1]]];
                    cdbFromLsb   <= doPop[1];
                    lastGrantLsb <= doPop[1];
                end
                if (|doDrop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: random and directed stimulus for cdb_arbiter, checked every
// cycle against a queue-based behavioural model plus literal expectations.
module tb_cdb_arbiter;

    localparam int RW    = 4;
    localparam int DEPTH = 4;

    logic          clockIn;
    logic          resetIn;
    logic          readyIn;
    logic          flushIn;
    logic          aluValid;
    logic [RW-1:0] aluRobIndex;
    logic [31:0]   aluVal;
    logic          aluFull;
    logic          lsbValid;
    logic [RW-1:0] lsbRobIndex;
    logic [31:0]   lsbVal;
    logic          lsbFull;
    logic          cdbValid;
    logic [RW-1:0] cdbRobIndex;
    logic [31:0]   cdbVal;
    logic          cdbFromLsb;
    logic          overflow;

    cdb_arbiter #(.ROB_WIDTH(RW), .QUEUE_WIDTH(2)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .flushIn(flushIn),
        .aluValid(aluValid), .aluRobIndex(aluRobIndex), .aluVal(aluVal), .aluFull(aluFull),
        .lsbValid(lsbValid), .lsbRobIndex(lsbRobIndex), .lsbVal(lsbVal), .lsbFull(lsbFull),
        .cdbValid(cdbValid), .cdbRobIndex(cdbRobIndex), .cdbVal(cdbVal),
        .cdbFromLsb(cdbFromLsb), .overflow(overflow)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [31:0]   val;
    } ent_t;

    // Behavioural model state.
    ent_t          aq[$];
    ent_t          lq[$];
    bit            mValid;
    logic [RW-1:0] mRob;
    logic [31:0]   mVal;
    bit            mFromLsb;
    bit            mOverflow;
    bit            mLastLsb;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        aq.delete();
        lq.delete();
        mValid    = 0;
        mRob      = '0;
        mVal      = '0;
        mFromLsb  = 0;
        mOverflow = 0;
        mLastLsb  = 1;
    endtask

    // One clock edge of the arbiter, from the rules: pop first, then push.
    task automatic modelStep();
        ent_t e;
        bit   gl;
        if (!readyIn) return;
        if (flushIn) begin
            aq.delete();
            lq.delete();
            mValid = 0;
            return;
        end
        if (aq.size() > 0 && lq.size() > 0) gl = !mLastLsb;
        else                                gl = (lq.size() > 0);
        mValid = 0;
        if (gl && lq.size() > 0) begin
            e = lq.pop_front();
            mValid = 1; mRob = e.rob; mVal = e.val; mFromLsb = 1; mLastLsb = 1;
        end else if (!gl && aq.size() > 0) begin
            e = aq.pop_front();
            mValid = 1; mRob = e.rob; mVal = e.val; mFromLsb = 0; mLastLsb = 0;
        end
        if (aluValid) begin
            if (aq.size() < DEPTH) aq.push_back('{rob: aluRobIndex, val: aluVal});
            else                   mOverflow = 1;
        end
        if (lsbValid) begin
            if (lq.size() < DEPTH) lq.push_back('{rob: lsbRobIndex, val: lsbVal});
            else                   mOverflow = 1;
        end
    endtask

    task automatic compareAll();
        chk("cdbValid",    32'(cdbValid),    32'(mValid));
        chk("cdbRobIndex", 32'(cdbRobIndex), 32'(mRob));
        chk("cdbVal",      cdbVal,           mVal);
        chk("cdbFromLsb",  32'(cdbFromLsb),  32'(mFromLsb));
        chk("overflow",    32'(overflow),    32'(mOverflow));
        chk("aluFull",     32'(aluFull),     32'(aq.size() >= DEPTH - 1));
        chk("lsbFull",     32'(lsbFull),     32'(lq.size() >= DEPTH - 1));
    endtask

    task automatic setIn(input bit rdy, input bit fl,
                         input bit av, input int ar, input logic [31:0] avl,
                         input bit lv, input int lr, input logic [31:0] lvl);
        readyIn     = rdy;
        flushIn     = fl;
        aluValid    = av;
        aluRobIndex = RW'(ar);
        aluVal      = avl;
        lsbValid    = lv;
        lsbRobIndex = RW'(lr);
        lsbVal      = lvl;
    endtask

    task automatic idle();
        setIn(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clockIn);
        modelStep();
        #1;
        compareAll();
    endtask

    // Asserts reset between edges, checks reset values before the next edge.
    task automatic asyncReset();
        #2 resetIn = 1'b0;
        #1;
        modelReset();
        compareAll();
        chk("rst_cdbValid", 32'(cdbValid), 32'd0);
        chk("rst_aluFull",  32'(aluFull),  32'd0);
        chk("rst_lsbFull",  32'(lsbFull),  32'd0);
        #1 resetIn = 1'b1;
    endtask

    task automatic checkCdb(input string name, input bit v, input int rob,
                            input logic [31:0] val, input bit fromLsb);
        chk({name, "_valid"}, 32'(cdbValid), 32'(v));
        if (v) begin
            chk({name, "_rob"},  32'(cdbRobIndex), 32'(rob));
            chk({name, "_val"},  cdbVal,           val);
            chk({name, "_from"}, 32'(cdbFromLsb),  32'(fromLsb));
        end
    endtask

    initial begin
        resetIn = 1'b0;
        idle();
        modelReset();
        #12;
        compareAll();
        chk("init_cdbRob",   32'(cdbRobIndex), 32'd0);
        chk("init_overflow", 32'(overflow),    32'd0);
        resetIn = 1'b1;

        // Single ALU result: visible only after the following edge.
        setIn(1, 0, 1, 3, 32'h11, 0, 0, 0);
        step(); checkCdb("single_e0", 0, 0, 0, 0);
        idle();
        step(); checkCdb("single_e1", 1, 3, 32'h11, 0);
        step(); checkCdb("single_e2", 0, 0, 0, 0);

        // Simultaneous results alternate by last grant.
        asyncReset();
        setIn(1, 0, 1, 1, 32'hA1, 1, 2, 32'hB2);
        step(); checkCdb("rr_e0", 0, 0, 0, 0);
        setIn(1, 0, 1, 4, 32'hA4, 1, 5, 32'hB5);
        step(); checkCdb("rr_e1", 1, 1, 32'hA1, 0);
        idle();
        step(); checkCdb("rr_e2", 1, 2, 32'hB2, 1);
        step(); checkCdb("rr_e3", 1, 4, 32'hA4, 0);
        step(); checkCdb("rr_e4", 1, 5, 32'hB5, 1);
        step(); checkCdb("rr_e5", 0, 0, 0, 0);

        // Fill both queues until a push is dropped.
        asyncReset();
        for (int i = 1; i <= 8; i++) begin
            setIn(1, 0, 1, i, 32'hA000 + 32'(i), 1, i + 8, 32'hB000 + 32'(i));
            step();
            if (i == 4) begin
                chk("fill4_aluFull", 32'(aluFull), 32'd0);
                chk("fill4_lsbFull", 32'(lsbFull), 32'd1);
            end
            if (i == 5) chk("fill5_aluFull", 32'(aluFull), 32'd1);
            if (i == 7) chk("fill7_overflow", 32'(overflow), 32'd0);
            if (i == 8) chk("fill8_overflow", 32'(overflow), 32'd1);
        end
        idle();
        for (int i = 0; i < 10; i++) step();
        chk("drain_overflow_sticky", 32'(overflow), 32'd1);

        // Flush with queued entries and a simultaneous push.
        asyncReset();
        for (int i = 0; i < 3; i++) begin
            setIn(1, 0, 1, i, 32'hC0 + 32'(i), 1, i + 4, 32'hD0 + 32'(i));
            step();
        end
        setIn(1, 1, 1, 9, 32'hEE, 0, 0, 0);
        step();
        chk("flush_cdbValid", 32'(cdbValid), 32'd0);
        chk("flush_aluFull",  32'(aluFull),  32'd0);
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("postflush_cdbValid", 32'(cdbValid), 32'd0);
        end

        // Stall with readyIn low: everything holds.
        asyncReset();
        for (int i = 0; i < 3; i++) begin
            setIn(1, 0, 1, i + 1, 32'h100 + 32'(i), 1, i + 8, 32'h200 + 32'(i));
            step();
        end
        setIn(0, 0, 1, 15, 32'hDEAD, 1, 14, 32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            step();
            checkCdb("stall", 1, 8, 32'h200, 1);
        end
        idle();
        for (int i = 0; i < 6; i++) step();

        // Async reset with both queues non-empty: no stale broadcast afterwards.
        for (int i = 0; i < 3; i++) begin
            setIn(1, 0, 1, i, 32'h300 + 32'(i), 1, i + 3, 32'h400 + 32'(i));
            step();
        end
        asyncReset();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst_cdbValid", 32'(cdbValid), 32'd0);
        end

        // Randomized traffic, sometimes respecting the full flags.
        for (int blk = 0; blk < 12; blk++) begin
            bit obey;
            obey = ($urandom % 2) == 1;
            for (int c = 0; c < 200; c++) begin
                bit av, lv;
                av = ($urandom % 3) != 0;
                lv = ($urandom % 3) != 0;
                if (obey) begin
                    av = av && !aluFull;
                    lv = lv && !lsbFull;
                end
                setIn(($urandom % 8) != 0, ($urandom % 40) == 0,
                      av, int'($urandom % 16), $urandom,
                      lv, int'($urandom % 16), $urandom);
                step();
            end
            asyncReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
